// File: rtl/axis_pkt_gen_pkg.sv
// Shared types, constants and helpers for the multi-channel AXI-Stream packet generator.
// The LFSR constants are only consumed when PKTGEN_LFSR_LEN_EN is defined.
package axis_pkt_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } state_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int          KEEP_MAX  = 128;

   // rem == 0 means a full final beat, so every byte lane is qualified
   function automatic logic [KEEP_MAX-1:0] keep_from_rem(input int unsigned rem,
                                                        input int unsigned bpb);
      logic [KEEP_MAX-1:0] one;
      one = KEEP_MAX'(1);
      if (rem == 0) return (one << bpb) - one;
      return (one << rem) - one;
   endfunction

   function automatic int unsigned beats_from_len(input int unsigned len,
                                                  input int unsigned bpb);
      return (len + bpb - 1) / bpb;
   endfunction

endpackage

// File: rtl/pkt_gen_rr_arb.sv
// Round-robin channel picker: first enabled channel strictly after the pointer, wrapping.
module pkt_gen_rr_arb #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] mask_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic [CH_W-1:0]   grant_o,
   output logic              any_en_o
);

   always_comb begin
      int   idx;
      logic found;
      idx     = 0;
      found   = 1'b0;
      grant_o = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = int'(ptr_i) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!found && mask_i[idx]) begin
            grant_o = CH_W'(idx);
            found   = 1'b1;
         end
      end
   end

   assign any_en_o = |mask_i;

endmodule

// File: rtl/axis_pkt_gen_mc.sv
// Multi-channel AXI-Stream packet generator with round-robin channel service and idle gaps.
// Define PKTGEN_LFSR_LEN_EN to randomise packet lengths in 1..cfg_len[ch] with a 16-bit LFSR.
module axis_pkt_gen_mc
   import axis_pkt_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_CH     = 4,
   parameter int SB_WIDTH   = 10,
   parameter int LEN_W      = 10,
   parameter int GAP_W      = 4,
   parameter int CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic                    stop,
   input  logic [NUM_CH-1:0]       ch_en,
   input  logic [NUM_CH*LEN_W-1:0] cfg_len,
   input  logic [GAP_W-1:0]        cfg_gap,
   input  logic [CNT_W-1:0]        cfg_num_pkts,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   output logic                    m_wlast,
   output logic [DATA_WIDTH/8-1:0] m_wkeep,
   output logic [SB_WIDTH-1:0]     m_wsideband,
   output logic                    busy,
   output logic                    done,
   output logic [CNT_W-1:0]        pkt_cnt
);

   localparam int BPB  = DATA_WIDTH / 8;
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   state_e                state_q, state_d;
   logic [CH_W-1:0]       ptr_q, ptr_d, ch_q, ch_d, grant;
   logic [LEN_W-1:0]      beats_q, beats_d, bidx_q, bidx_d;
   logic [BPB-1:0]        lkeep_q, lkeep_d, keep_q, keep_d;
   logic [7:0]            bcnt_q, bcnt_d;
   logic [CNT_W-1:0]      pcnt_q, pcnt_d, pcnt_plus1;
   logic [GAP_W-1:0]      gap_q, gap_d;
   logic                  valid_q, valid_d, last_q, last_d, done_q, done_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [SB_WIDTH-1:0]   sb_q, sb_d;
   logic                  any_en;
   logic [LEN_W-1:0]      cfg_sel, len_eff, beats_new;
   logic [BPB-1:0]        keep_new;
   logic [LEN_W:0]        bidx_p2;

   pkt_gen_rr_arb #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
      .mask_i   (ch_en),
      .ptr_i    (ptr_q),
      .grant_o  (grant),
      .any_en_o (any_en)
   );

   assign cfg_sel = cfg_len[int'(grant)*LEN_W +: LEN_W];

`ifdef PKTGEN_LFSR_LEN_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (state_q == ST_ARB) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign len_eff = (cfg_sel == '0) ? LEN_W'(1)
                  : LEN_W'(({16'h0000, lfsr_q} % 32'(cfg_sel)) + 32'd1);
`else
   assign len_eff = (cfg_sel == '0) ? LEN_W'(1) : cfg_sel;
`endif

   assign beats_new  = LEN_W'(beats_from_len(int'(len_eff), BPB));
   assign keep_new   = BPB'(keep_from_rem(int'(len_eff) % BPB, BPB));
   assign bidx_p2    = {1'b0, bidx_q} + (LEN_W+1)'(2);
   assign pcnt_plus1 = pcnt_q + CNT_W'(1);

   // Top byte carries the packet number, the rest carry the running beat count
   function automatic logic [DATA_WIDTH-1:0] mk_data(input logic [7:0] pk, input logic [7:0] bc);
      logic [DATA_WIDTH-1:0] d;
      for (int b = 0; b < BPB; b++) d[b*8 +: 8] = (b == BPB-1) ? pk : bc;
      return d;
   endfunction

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      ch_d    = ch_q;
      beats_d = beats_q;
      bidx_d  = bidx_q;
      lkeep_d = lkeep_q;
      keep_d  = keep_q;
      bcnt_d  = bcnt_q;
      pcnt_d  = pcnt_q;
      gap_d   = gap_q;
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      sb_d    = sb_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (ch_en != '0) begin
                  pcnt_d  = '0;
                  state_d = ST_ARB;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_ARB: begin
            if (stop || !any_en) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               ch_d    = grant;
               beats_d = beats_new;
               bidx_d  = '0;
               lkeep_d = keep_new;
               valid_d = 1'b1;
               data_d  = mk_data(pcnt_q[7:0], bcnt_q);
               last_d  = (beats_new == LEN_W'(1));
               keep_d  = (beats_new == LEN_W'(1)) ? keep_new : '1;
               sb_d    = SB_WIDTH'(grant);
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (valid_q && m_wready) begin
               bcnt_d = bcnt_q + 8'd1;
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  pcnt_d  = (&pcnt_q) ? pcnt_q : pcnt_plus1;
                  ptr_d   = ch_q;
                  if (cfg_num_pkts != '0 && pcnt_plus1 == cfg_num_pkts) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else if (cfg_gap == '0) begin
                     state_d = ST_ARB;
                  end else begin
                     gap_d   = cfg_gap;
                     state_d = ST_GAP;
                  end
               end else begin
                  bidx_d = bidx_q + LEN_W'(1);
                  data_d = mk_data(pcnt_q[7:0], bcnt_q + 8'd1);
                  last_d = (bidx_p2 == {1'b0, beats_q});
                  keep_d = (bidx_p2 == {1'b0, beats_q}) ? lkeep_q : '1;
               end
            end
         end
         ST_GAP: begin
            if (gap_q <= GAP_W'(1)) state_d = ST_ARB;
            else                    gap_d   = gap_q - GAP_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         ptr_q   <= CH_W'(NUM_CH-1);
         ch_q    <= '0;
         beats_q <= '0;
         bidx_q  <= '0;
         lkeep_q <= '0;
         keep_q  <= '0;
         bcnt_q  <= '0;
         pcnt_q  <= '0;
         gap_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
         sb_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ch_q    <= ch_d;
         beats_q <= beats_d;
         bidx_q  <= bidx_d;
         lkeep_q <= lkeep_d;
         keep_q  <= keep_d;
         bcnt_q  <= bcnt_d;
         pcnt_q  <= pcnt_d;
         gap_q   <= gap_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         data_q  <= data_d;
         sb_q    <= sb_d;
         done_q  <= done_d;
      end
   end

   assign m_wdata     = data_q;
   assign m_wvalid    = valid_q;
   assign m_wlast     = last_q;
   assign m_wkeep     = keep_q;
   assign m_wsideband = sb_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign pkt_cnt     = pcnt_q;

endmodule

// File: tb/tb_axis_pkt_gen_mc.sv
// Scoreboard bench for axis_pkt_gen_mc: a packet-level model queues expected beats,
// a monitor pops and compares them on every handshake.
module tb_axis_pkt_gen_mc;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic [9:0]  sb;
   } beat_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [3:0]  ch_en = '0;
   logic [39:0] cfg_len = '0;
   logic [3:0]  cfg_gap = '0;
   logic [15:0] cfg_num_pkts = '0;
   logic [63:0] m_wdata;
   logic        m_wvalid;
   logic        m_wready = 1'b1;
   logic        m_wlast;
   logic [7:0]  m_wkeep;
   logic [9:0]  m_wsideband;
   logic        busy;
   logic        done;
   logic [15:0] pkt_cnt;

   int    checks = 0;
   int    failures = 0;
   beat_t exp_q[$];
   int    lens_a[4];
   int    m_bc = 0;
   int    m_ptr = 3;
   int    cyc = 0;
   int    last_hs_cyc = -1;
   int    hs_total = 0;
   int    cur_gap = 0;
   int    rdy_mode = 0;

   axis_pkt_gen_mc #(
      .DATA_WIDTH(64), .NUM_CH(4), .SB_WIDTH(10), .LEN_W(10), .GAP_W(4), .CNT_W(16)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .start        (start),
      .stop         (stop),
      .ch_en        (ch_en),
      .cfg_len      (cfg_len),
      .cfg_gap      (cfg_gap),
      .cfg_num_pkts (cfg_num_pkts),
      .m_wdata      (m_wdata),
      .m_wvalid     (m_wvalid),
      .m_wready     (m_wready),
      .m_wlast      (m_wlast),
      .m_wkeep      (m_wkeep),
      .m_wsideband  (m_wsideband),
      .busy         (busy),
      .done         (done),
      .pkt_cnt      (pkt_cnt)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Sink ready: 0 = always ready, 1 = one high then two low, 2 = random ~75% ready
   initial begin
      int phase;
      phase = 0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1:       m_wready = (phase == 0);
            2:       m_wready = ($urandom_range(0, 3) != 0);
            default: m_wready = 1'b1;
         endcase
         phase = (phase == 2) ? 0 : phase + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic driveLens();
      for (int k = 0; k < 4; k++) cfg_len[k*10 +: 10] = 10'(lens_a[k]);
   endtask

   // Packet-level reference: channel order, byte lengths and payload pattern for one run
   task automatic modelRun(input logic [3:0] mask, input int num);
      for (int p = 0; p < num; p++) begin
         int ch, len, nb, rem;
         ch = -1;
         for (int s = 1; s <= 4; s++)
            if (ch < 0 && mask[(m_ptr + s) % 4]) ch = (m_ptr + s) % 4;
         len = (lens_a[ch] == 0) ? 1 : lens_a[ch];
         nb  = (len + 7) / 8;
         rem = len % 8;
         for (int b = 0; b < nb; b++) begin
            beat_t e;
            for (int k = 0; k < 7; k++) e.data[k*8 +: 8] = 8'(m_bc);
            e.data[63:56] = 8'(p);
            e.keep = (b == nb - 1 && rem != 0) ? (8'hFF >> (8 - rem)) : 8'hFF;
            e.last = (b == nb - 1);
            e.sb   = 10'(ch);
            exp_q.push_back(e);
            m_bc = (m_bc + 1) % 256;
         end
         m_ptr = ch;
      end
   endtask

   // Monitor: handshake scoreboard, backpressure hold check, inter-packet latency
   initial begin
      logic        prev_valid, holding;
      logic [82:0] held;
      beat_t       e;
      prev_valid = 1'b0;
      holding    = 1'b0;
      held       = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            prev_valid = 1'b0;
            holding    = 1'b0;
         end else begin
            if (holding) begin
               checkOutput("hold_valid", 64'(m_wvalid), 64'd1);
               if (m_wvalid)
                  checkOutput("hold_beat", 64'({m_wdata, m_wkeep, m_wlast, m_wsideband} != held), 64'd0);
            end
            if (m_wvalid && !prev_valid && last_hs_cyc >= 0)
               checkOutput("ipg_latency", 64'(cyc - last_hs_cyc), 64'(2 + cur_gap));
            if (m_wvalid && m_wready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_beat actual=data 0x%0h expected=no beat", m_wdata);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("beat_data", m_wdata, e.data);
                  checkOutput("beat_keep", 64'(m_wkeep), 64'(e.keep));
                  checkOutput("beat_last", 64'(m_wlast), 64'(e.last));
                  checkOutput("beat_sideband", 64'(m_wsideband), 64'(e.sb));
               end
               hs_total++;
               if (m_wlast) last_hs_cyc = cyc;
               holding = 1'b0;
            end else if (m_wvalid) begin
               holding = 1'b1;
               held    = {m_wdata, m_wkeep, m_wlast, m_wsideband};
            end else begin
               holding = 1'b0;
            end
            prev_valid = m_wvalid;
         end
      end
   end

   task automatic pulseStart(input bit chkByte0);
      int lat;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 1;
      while (!m_wvalid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("start_latency", 64'(lat), 64'd2);
      if (chkByte0) checkOutput("first_byte0", 64'(m_wdata[7:0]), 64'd0);
   endtask

   task automatic waitDone(input int expCnt, input int expDiff);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 4000 && !seen; n++) begin
         @(negedge clk);
         seen = done;
      end
      checkOutput("done_seen", 64'(seen), 64'd1);
      if (seen) begin
         checkOutput("pkt_cnt", 64'(pkt_cnt), 64'(expCnt));
         checkOutput("busy_at_done", 64'(busy), 64'd0);
         checkOutput("done_timing", 64'(cyc - last_hs_cyc), 64'(expDiff));
         checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);
         @(negedge clk);
         checkOutput("done_pulse_width", 64'(done), 64'd0);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] mask, input int num, input int gap);
      @(posedge clk);
      #1;
      ch_en        = mask;
      cfg_gap      = 4'(gap);
      cfg_num_pkts = 16'(num);
      cur_gap      = gap;
      driveLens();
      modelRun(mask, num);
      last_hs_cyc = -1;
      pulseStart(1'b0);
      waitDone(num, 1);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int hs0, n;
      bit seen_v;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_valid", 64'(m_wvalid), 64'd0);
      checkOutput("rst_last", 64'(m_wlast), 64'd0);
      checkOutput("rst_keep", 64'(m_wkeep), 64'd0);
      checkOutput("rst_data", m_wdata, 64'd0);
      checkOutput("rst_sideband", 64'(m_wsideband), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);

      $display("[TB] sideband round robin over mask 1011");
      lens_a = '{8, 8, 8, 8};
      applyStimulus(4'b1011, 6, 0);

      $display("[TB] single channel 64-byte packets");
      lens_a = '{64, 8, 8, 8};
      applyStimulus(4'b0001, 2, 0);

      $display("[TB] 13-byte packet partial keep");
      lens_a = '{13, 8, 8, 8};
      applyStimulus(4'b0001, 1, 0);

      $display("[TB] backpressure 1 high / 2 low");
      rdy_mode = 1;
      lens_a = '{40, 8, 8, 8};
      hs0 = hs_total;
      applyStimulus(4'b0001, 1, 2);
      checkOutput("bp_handshakes", 64'(hs_total - hs0), 64'd5);

      $display("[TB] randomised runs");
      rdy_mode = 2;
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 4; k++) lens_a[k] = $urandom_range(0, 80);
         applyStimulus(4'($urandom_range(1, 15)), $urandom_range(1, 5), $urandom_range(0, 3));
      end
      rdy_mode = 0;

      $display("[TB] start with empty mask");
      @(posedge clk);
      #1 ch_en = 4'b0000;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      checkOutput("empty_mask_done", 64'(done), 64'd1);
      checkOutput("empty_mask_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1 checkOutput("empty_mask_done_pulse", 64'(done), 64'd0);

      $display("[TB] stop during packet 3 of unlimited run");
      lens_a = '{32, 32, 32, 32};
      ch_en = 4'b0101;
      cfg_gap = 4'd0;
      cur_gap = 0;
      cfg_num_pkts = 16'd0;
      driveLens();
      modelRun(4'b0101, 3);
      last_hs_cyc = -1;
      hs0 = hs_total;
      pulseStart(1'b0);
      for (n = 0; n < 200 && hs_total < hs0 + 9; n++) @(posedge clk);
      #1 stop = 1'b1;
      waitDone(3, 2);
      seen_v = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_wvalid) seen_v = 1'b1;
      end
      checkOutput("idle_after_stop", 64'(seen_v), 64'd0);
      @(posedge clk);
      #1 stop = 1'b0;

      $display("[TB] async reset mid packet");
      lens_a = '{64, 8, 8, 8};
      ch_en = 4'b0001;
      cfg_num_pkts = 16'd1;
      driveLens();
      modelRun(4'b0001, 1);
      last_hs_cyc = -1;
      hs0 = hs_total;
      pulseStart(1'b0);
      for (n = 0; n < 100 && hs_total < hs0 + 1; n++) @(posedge clk);
      #2 checkOutput("pre_reset_valid", 64'(m_wvalid), 64'd1);
      rstn = 1'b0;
      #1 checkOutput("async_reset_valid", 64'(m_wvalid), 64'd0);
      checkOutput("async_reset_busy", 64'(busy), 64'd0);
      exp_q.delete();
      m_bc = 0;
      m_ptr = 3;
      last_hs_cyc = -1;
      @(posedge clk);
      #3 rstn = 1'b1;
      @(posedge clk);
      #1;
      lens_a = '{8, 8, 8, 8};
      driveLens();
      modelRun(4'b0001, 1);
      pulseStart(1'b1);
      waitDone(1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
